// File: rtl/turn_timer.sv
// Player-turn countdown timer: counts TURN_SECONDS whole seconds while en is high,
// raises timeout when the turn runs out and shows remaining seconds as two BCD digits.
module turn_timer #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TURN_SECONDS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       timeout,
    output logic       running,
    output logic       sec_tick,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones
);

    localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [6:0]      SECS_INIT = 7'(TURN_SECONDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] presc, presc_next;
    logic [6:0]    secs, secs_next;
    logic          tick_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            secs     <= SECS_INIT;
            sec_tick <= 1'b0;
        end else begin
            state    <= state_next;
            presc    <= presc_next;
            secs     <= secs_next;
            sec_tick <= tick_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        presc_next = presc;
        secs_next  = secs;
        tick_next  = 1'b0;
        unique case (state)
            IDLE: begin
                secs_next  = SECS_INIT;
                presc_next = '0;
                if (en) state_next = RUN;
            end
            RUN: begin
                if (!en) begin
                    // Turn ended early: abandon the count without a tick or timeout.
                    state_next = IDLE;
                    secs_next  = SECS_INIT;
                    presc_next = '0;
                end else if (presc == PRESC_MAX) begin
                    presc_next = '0;
                    tick_next  = 1'b1;
                    if (secs <= 7'd1) begin
                        secs_next  = '0;
                        state_next = EXPIRED;
                    end else begin
                        secs_next = secs - 7'd1;
                    end
                end else begin
                    presc_next = presc + 1'b1;
                end
            end
            EXPIRED: begin
                secs_next  = '0;
                presc_next = '0;
                if (!en) begin
                    state_next = IDLE;
                    secs_next  = SECS_INIT;
                end
            end
            default: begin
                state_next = IDLE;
                secs_next  = SECS_INIT;
                presc_next = '0;
            end
        endcase
    end

    assign timeout   = (state == EXPIRED);
    assign running   = (state == RUN);
    assign secs_tens = 4'(secs / 7'd10);
    assign secs_ones = 4'(secs % 7'd10);

endmodule

// File: tb/tb_turn_timer.sv
// Scoreboard bench for turn_timer: a seconds-level model predicts every sample,
// a monitor compares it against two instances (3 s and default 15 s turns, 4 Hz clock).
module tb_turn_timer;

    localparam int C = 4;

    typedef struct {
        int         id;
        logic [10:0] v;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    logic       to0, run0, tk0, to1, run1, tk1;
    logic [3:0] tens0, ones0, tens1, ones1;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    int turn[2] = '{3, 15};
    int m_mode[2];  // 0 waiting, 1 counting, 2 out of time
    int m_n[2];     // edges spent counting in the current turn

    turn_timer #(.CLK_HZ(C), .TURN_SECONDS(3)) dut0 (
        .clk(clk), .rst(rst), .en(en),
        .timeout(to0), .running(run0), .sec_tick(tk0),
        .secs_tens(tens0), .secs_ones(ones0)
    );

    turn_timer #(.CLK_HZ(C)) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .timeout(to1), .running(run1), .sec_tick(tk1),
        .secs_tens(tens1), .secs_ones(ones1)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] m_out(input int i, input logic tick);
        int rem;
        rem = (m_mode[i] == 1) ? turn[i] - m_n[i] / C : (m_mode[i] == 2) ? 0 : turn[i];
        return {m_mode[i] == 2, m_mode[i] == 1, tick, 4'(rem / 10), 4'(rem % 10)};
    endfunction

    task automatic push(input int i, input logic tick);
        exp_t e;
        e.id  = i;
        e.v   = m_out(i, tick);
        e.tag = phase;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_n[i]    = 0;
            push(i, 1'b0);
        end
    endtask

    task automatic model_edge(input logic e);
        logic tick;
        for (int i = 0; i < 2; i++) begin
            tick = 1'b0;
            case (m_mode[i])
                0: if (e) begin m_mode[i] = 1; m_n[i] = 0; end
                1: if (!e) m_mode[i] = 0;
                   else begin
                       m_n[i]++;
                       if (m_n[i] % C == 0) tick = 1'b1;
                       if (m_n[i] == turn[i] * C) m_mode[i] = 2;
                   end
                default: if (!e) m_mode[i] = 0;
            endcase
            push(i, tick);
        end
    endtask

    task automatic step(input logic e);
        @(negedge clk);
        rst = 1'b0;
        en  = e;
        model_edge(e);
    endtask

    task automatic steps(input logic e, input int n);
        for (int k = 0; k < n; k++) step(e);
    endtask

    // Asynchronous reset mid-cycle, then held across one rising edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        model_reset();
        rst = 1'b1;
        #2;
        model_reset();
    endtask

    task automatic check(input string name, input int id, input logic [10:0] act, input logic [10:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s dut%0d: got {to,run,tick,tens,ones}=%b want %b at %0t", name, id, act, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.id == 0) check(e.tag, 0, {to0, run0, tk0, tens0, ones0}, e.v);
                else           check(e.tag, 1, {to1, run1, tk1, tens1, ones1}, e.v);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        phase = "reset";
        do_reset();

        phase = "full_countdown";
        steps(1'b1, 13);
        phase = "expired_hold";
        steps(1'b1, 5);
        step(1'b0);
        phase = "rearm";
        steps(1'b1, 13);
        step(1'b0);
        step(1'b1);
        steps(1'b1, 13);
        steps(1'b0, 2);

        phase = "early_abort";
        steps(1'b1, 6);
        steps(1'b0, 3);

        phase = "reset_mid_run";
        steps(1'b1, 8);
        do_reset();
        steps(1'b0, 2);
        steps(1'b1, 14);
        steps(1'b0, 2);

        phase = "long_turn";
        steps(1'b1, 64);
        steps(1'b0, 2);

        phase = "random";
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 15) != 0);
        end
        steps(1'b0, 2);

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/turn_timer.md
TURN_TIMER -- requirements
Module: turn_timer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clock cycles per second; legal range 2 or more.
REQ-002 Parameter TURN_SECONDS, default 15, length of the player turn in seconds; legal range 1..99.
REQ-003 Port clk, input, 1, single system clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-high.
REQ-005 Port en, input, 1, count enable; driven by the game controller's Timer output, high only during the player-turn state.
REQ-006 Port timeout, output, 1, turn expired; wired to the game controller's T input.
REQ-007 Port running, output, 1, high while a turn countdown is in progress.
REQ-008 Port sec_tick, output, 1, one-cycle pulse on each whole-second decrement.
REQ-009 Port secs_tens, output, 4, BCD tens digit of the remaining seconds, for the 7-segment display.
REQ-010 Port secs_ones, output, 4, BCD ones digit of the remaining seconds.

Function
REQ-011 Internal state SHALL be a three-state FSM: IDLE, RUN, EXPIRED.
REQ-012 Internal registers SHALL be a prescaler of width ceil(log2(CLK_HZ)) and a seconds counter secs of 7 bits.
REQ-013 IDLE: secs SHALL hold TURN_SECONDS and prescaler SHALL hold 0; on an edge with en=1 the FSM SHALL go to RUN, reloading secs=TURN_SECONDS and prescaler=0.
REQ-014 RUN, en=1, prescaler /= CLK_HZ-1: prescaler SHALL increment by 1 and secs SHALL hold.
REQ-015 RUN, en=1, prescaler == CLK_HZ-1: prescaler SHALL clear to 0, secs SHALL decrement by 1, and sec_tick SHALL be registered high for exactly the following cycle.
REQ-016 RUN, same edge as REQ-015 with secs==1: the FSM SHALL go to EXPIRED, with secs becoming 0.
REQ-017 Latency: timeout SHALL rise exactly TURN_SECONDS*CLK_HZ rising edges after the edge that entered RUN.
REQ-018 RUN, en=0 (turn ended early, e.g. the player fired): the FSM SHALL go to IDLE on that edge, reload secs=TURN_SECONDS and prescaler=0, and SHALL NOT assert timeout or sec_tick.
REQ-019 EXPIRED: timeout SHALL be high, secs SHALL hold 0, and the prescaler SHALL hold 0.
REQ-020 EXPIRED: the FSM SHALL go to IDLE on the first edge with en=0 and SHALL stay in EXPIRED while en=1.
REQ-021 Output decode: timeout = (state==EXPIRED) and running = (state==RUN), both decoded from the state register.
REQ-022 secs_tens = secs/10 and secs_ones = secs%10, decoded combinationally from the secs register; each is always a valid BCD digit 0..9.
REQ-023 Re-arm: if en falls and rises again, the next entry into RUN SHALL restart the full TURN_SECONDS count with no carry-over of prescaler state.
REQ-024 Wrap-around: secs SHALL never decrement below 0 and the prescaler SHALL never exceed CLK_HZ-1.
REQ-025 Illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-026 While rst=1 the block SHALL go to IDLE asynchronously with state=IDLE, prescaler=0, secs=TURN_SECONDS, sec_tick=0.
REQ-027 Output values under reset SHALL be timeout=0, running=0, sec_tick=0, and secs_tens/secs_ones showing TURN_SECONDS (1/5 at default).
REQ-028 Reset asserted mid-count or in EXPIRED SHALL abort immediately; after release the block SHALL wait in IDLE for en.

Verification (CLK_HZ=4, TURN_SECONDS=3)
REQ-029 Full countdown: hold en=1 from edge 0 -> running=1 from edge 0; sec_tick pulses after edges 4, 8 and 12; timeout rises at edge 12; secs_ones reads 3,2,1,0.
REQ-030 Early abort: en=1 for 6 edges then en=0 -> IDLE on the next edge, secs_ones=3, timeout never asserted.
REQ-031 Expired hold: keep en=1 for 5 edges past timeout -> timeout stays 1 and secs stays 0; drop en -> timeout=0 on the next edge.
REQ-032 Reset mid-run: assert rst between edges 7 and 8 -> all outputs return to their reset values before the next edge with no sec_tick; re-enabling restarts a full 12-edge count.
REQ-033 Re-arm: run to timeout, drop en for 1 cycle, raise en -> timeout rises again exactly 12 edges later.
REQ-034 Default parameters (TURN_SECONDS=15): in reset -> secs_tens=1 and secs_ones=5; one tick into RUN -> 1/4.
